// File: rtl/sprite_cfg_ctrl.sv
// sprite_cfg_ctrl: SPI mode-0 command decoder for the sprite engine.
// Position/colour land in shadow regs and commit on next_frame.
module sprite_cfg_ctrl #(
    parameter int SPRITE_BYTES = 18,
    parameter int ADDR_W       = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              spi_sclk,
    input  logic              spi_mosi,
    input  logic              spi_cs,
    output logic              spi_miso,
    input  logic              next_frame,
    output logic [9:0]        sprite_x,
    output logic [9:0]        sprite_y,
    output logic [5:0]        color_bg,
    output logic [5:0]        color_1,
    output logic [5:0]        color_2,
    output logic              spr_wr_en,
    output logic [ADDR_W-1:0] spr_wr_addr,
    output logic [7:0]        spr_wr_data
);

    localparam logic [7:0] OP_SET_X   = 8'h01;
    localparam logic [7:0] OP_SET_Y   = 8'h02;
    localparam logic [7:0] OP_SET_COL = 8'h03;
    localparam logic [7:0] OP_WR_SPR  = 8'h04;
    localparam logic [7:0] OP_STATUS  = 8'h05;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SPRITE_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ARGS, S_SPRITE, S_STATUS, S_DISCARD
    } state_t;

    state_t state_q, state_d;

    logic [2:0] sclk_sr;
    logic [1:0] mosi_sr;
    logic [1:0] cs_sr;
    logic       cs_idle, sclk_rise, sclk_fall, mosi_b;
    logic [2:0] bit_cnt;
    logic [6:0] rx_sr;
    logic [7:0] rx_byte;
    logic       byte_done, is_set;
    logic [1:0] cmd_q, arg_cnt;
    logic [5:0] stage0, stage1;
    logic       arg_last, shadow_we, spr_we, stat_cap;
    logic [9:0] sh_x_q, sh_y_q, sh_x_d, sh_y_d;
    logic [5:0] sh_bg_q, sh_c1_q, sh_c2_q;
    logic [5:0] sh_bg_d, sh_c1_d, sh_c2_d;
    logic       pending, tx_armed;
    logic [7:0] frame_cnt, stat_q, tx_sr;
    logic [ADDR_W-1:0] wr_ptr;

    assign cs_idle   = cs_sr[1];
    assign mosi_b    = mosi_sr[1];
    assign sclk_rise = sclk_sr[1] & ~sclk_sr[2];
    assign sclk_fall = ~sclk_sr[1] & sclk_sr[2];
    assign rx_byte   = {rx_sr, mosi_b};
    assign byte_done = ~cs_idle & sclk_rise & (bit_cnt == 3'd7);
    assign is_set    = (rx_byte == OP_SET_X) | (rx_byte == OP_SET_Y) |
                       (rx_byte == OP_SET_COL);
    assign arg_last  = (cmd_q == 2'd3) ? (arg_cnt == 2'd2) : (arg_cnt == 2'd1);
    assign spi_miso  = (state_q == S_STATUS) & ~cs_idle & tx_sr[7];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sr <= 3'b000;
            mosi_sr <= 2'b00;
            cs_sr   <= 2'b11;
        end else begin
            sclk_sr <= {sclk_sr[1:0], spi_sclk};
            mosi_sr <= {mosi_sr[0], spi_mosi};
            cs_sr   <= {cs_sr[0], spi_cs};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt <= 3'd0;
            rx_sr   <= 7'd0;
        end else if (cs_idle) begin
            bit_cnt <= 3'd0;
        end else if (sclk_rise) begin
            bit_cnt <= bit_cnt + 3'd1;
            rx_sr   <= {rx_sr[5:0], mosi_b};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        shadow_we = 1'b0;
        spr_we    = 1'b0;
        stat_cap  = 1'b0;
        if (cs_idle) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: state_d = S_CMD;
                S_CMD: begin
                    if (byte_done) begin
                        unique case (1'b1)
                            is_set:               state_d = S_ARGS;
                            rx_byte == OP_WR_SPR: state_d = S_SPRITE;
                            rx_byte == OP_STATUS: begin
                                state_d  = S_STATUS;
                                stat_cap = 1'b1;
                            end
                            default:              state_d = S_DISCARD;
                        endcase
                    end
                end
                S_ARGS: begin
                    if (byte_done && arg_last) begin
                        shadow_we = 1'b1;
                        state_d   = S_DISCARD;
                    end
                end
                S_SPRITE: spr_we = byte_done;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_q   <= 2'd0;
            arg_cnt <= 2'd0;
            stage0  <= 6'd0;
            stage1  <= 6'd0;
        end else if (cs_idle) begin
            arg_cnt <= 2'd0;
        end else if (byte_done) begin
            if (state_q == S_CMD) cmd_q <= rx_byte[1:0];
            if (state_q == S_ARGS) begin
                arg_cnt <= arg_cnt + 2'd1;
                if (arg_cnt == 2'd0) stage0 <= rx_byte[5:0];
                if (arg_cnt == 2'd1) stage1 <= rx_byte[5:0];
            end
        end
    end

    // next shadow value, so a same-cycle frame commit sees the new write
    always_comb begin
        sh_x_d  = sh_x_q;
        sh_y_d  = sh_y_q;
        sh_bg_d = sh_bg_q;
        sh_c1_d = sh_c1_q;
        sh_c2_d = sh_c2_q;
        if (shadow_we) begin
            unique case (cmd_q)
                2'd1: sh_x_d = {stage0[1:0], rx_byte};
                2'd2: sh_y_d = {stage0[1:0], rx_byte};
                default: begin
                    sh_bg_d = stage0;
                    sh_c1_d = stage1;
                    sh_c2_d = rx_byte[5:0];
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh_x_q    <= 10'd0;
            sh_y_q    <= 10'd0;
            sh_bg_q   <= 6'h00;
            sh_c1_q   <= 6'h3F;
            sh_c2_q   <= 6'h30;
            sprite_x  <= 10'd0;
            sprite_y  <= 10'd0;
            color_bg  <= 6'h00;
            color_1   <= 6'h3F;
            color_2   <= 6'h30;
            pending   <= 1'b0;
            frame_cnt <= 8'd0;
        end else begin
            sh_x_q  <= sh_x_d;
            sh_y_q  <= sh_y_d;
            sh_bg_q <= sh_bg_d;
            sh_c1_q <= sh_c1_d;
            sh_c2_q <= sh_c2_d;
            if (next_frame) begin
                sprite_x  <= sh_x_d;
                sprite_y  <= sh_y_d;
                color_bg  <= sh_bg_d;
                color_1   <= sh_c1_d;
                color_2   <= sh_c2_d;
                pending   <= 1'b0;
                frame_cnt <= frame_cnt + 8'd1;
            end else if (shadow_we) begin
                pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            spr_wr_en   <= 1'b0;
            spr_wr_addr <= '0;
            spr_wr_data <= 8'd0;
        end else begin
            spr_wr_en <= spr_we;
            if (state_q != S_SPRITE) begin
                wr_ptr <= '0;
            end else if (spr_we) begin
                spr_wr_addr <= wr_ptr;
                spr_wr_data <= rx_byte;
                wr_ptr <= (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + ADDR_W'(1);
            end
        end
    end

    // first falling edge in STATUS loads the byte, later ones shift
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_q   <= 8'd0;
            tx_sr    <= 8'd0;
            tx_armed <= 1'b0;
        end else begin
            if (stat_cap) stat_q <= {pending, frame_cnt[6:0]};
            if (state_q != S_STATUS) begin
                tx_sr    <= 8'd0;
                tx_armed <= 1'b0;
            end else if (sclk_fall) begin
                tx_armed <= 1'b1;
                tx_sr    <= tx_armed ? {tx_sr[6:0], 1'b0} : stat_q;
            end
        end
    end

endmodule

// File: tb/tb_sprite_cfg_ctrl.sv
// tb_sprite_cfg_ctrl: randomized SPI command traffic checked against
// a transaction-level model of shadow/active regs and sprite writes.
module tb_sprite_cfg_ctrl;

    localparam int HALF   = 6;
    localparam int NBYTES = 18;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       spi_sclk, spi_mosi, spi_cs, spi_miso;
    logic       next_frame;
    logic [9:0] sprite_x, sprite_y;
    logic [5:0] color_bg, color_1, color_2;
    logic       spr_wr_en;
    logic [4:0] spr_wr_addr;
    logic [7:0] spr_wr_data;

    always #5 clk = ~clk;

    sprite_cfg_ctrl #(.SPRITE_BYTES(NBYTES), .ADDR_W(5)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .spi_sclk    (spi_sclk),
        .spi_mosi    (spi_mosi),
        .spi_cs      (spi_cs),
        .spi_miso    (spi_miso),
        .next_frame  (next_frame),
        .sprite_x    (sprite_x),
        .sprite_y    (sprite_y),
        .color_bg    (color_bg),
        .color_1     (color_1),
        .color_2     (color_2),
        .spr_wr_en   (spr_wr_en),
        .spr_wr_addr (spr_wr_addr),
        .spr_wr_data (spr_wr_data)
    );

    int checks = 0;
    int errors = 0;

    int m_sx, m_sy, m_bg, m_c1, m_c2;
    int s_sx, s_sy, s_bg, s_c1, s_c2;
    bit m_pend;
    int m_fc;

    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    int         wa_q[$];
    int         wd_q[$];
    logic [9:0] nf_snap;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (spr_wr_en === 1'b1) begin
            wa_q.push_back(int'(spr_wr_addr));
            wd_q.push_back(int'(spr_wr_data));
        end
    end

    task automatic model_reset();
        m_sx = 0; m_sy = 0; m_bg = 0; m_c1 = 'h3F; m_c2 = 'h30;
        s_sx = 0; s_sy = 0; s_bg = 0; s_c1 = 'h3F; s_c2 = 'h30;
        m_pend = 1'b0;
        m_fc = 0;
    endtask

    task automatic model_commit();
        m_sx = s_sx; m_sy = s_sy;
        m_bg = s_bg; m_c1 = s_c1; m_c2 = s_c2;
        m_pend = 1'b0;
        m_fc = (m_fc + 1) % 256;
    endtask

    task automatic check_active(input string tag);
        chk({tag, "_x"}, sprite_x, m_sx);
        chk({tag, "_y"}, sprite_y, m_sy);
        chk({tag, "_bg"}, color_bg, m_bg);
        chk({tag, "_c1"}, color_1, m_c1);
        chk({tag, "_c2"}, color_2, m_c2);
    endtask

    task automatic spi_xfer(input logic [7:0] b, input bit nf_last,
                            output logic [7:0] rb);
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk);
            spi_mosi = b[i];
            repeat (HALF) @(negedge clk);
            rb[i] = spi_miso;
            spi_sclk = 1'b1;
            if (nf_last && i == 0) begin
                // land next_frame on the clk that completes this byte
                repeat (2) @(negedge clk);
                next_frame = 1'b1;
                @(negedge clk);
                next_frame = 1'b0;
                nf_snap = sprite_x;
                repeat (HALF - 3) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            spi_sclk = 1'b0;
        end
    endtask

    task automatic run_txn(input bit nf_last);
        logic [7:0] r;
        @(negedge clk);
        spi_cs = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int k = 0; k < tx_q.size(); k++) begin
            spi_xfer(tx_q[k], nf_last && (k == tx_q.size() - 1), r);
            rx_q.push_back(r);
        end
        repeat (HALF) @(negedge clk);
        spi_cs = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic apply_txn(input bit nf_last);
        int n, ne, nc;
        logic [7:0] op, exp_st;
        wa_q.delete();
        wd_q.delete();
        rx_q.delete();
        exp_st = 8'((m_pend ? 128 : 0) + (m_fc % 128));
        run_txn(nf_last);
        n  = tx_q.size();
        op = tx_q[0];
        ne = (op == 8'h04) ? n - 1 : 0;
        chk("strobe_cnt", wa_q.size(), ne);
        nc = (wa_q.size() < ne) ? wa_q.size() : ne;
        for (int i = 0; i < nc; i++) begin
            chk("spr_addr", wa_q[i], i % NBYTES);
            chk("spr_data", wd_q[i], tx_q[i + 1]);
        end
        if (op == 8'h05) begin
            chk("miso_opcode", rx_q[0], 0);
            for (int i = 1; i < n; i++)
                chk("status", rx_q[i], (i == 1) ? exp_st : 8'h00);
        end
        case (op)
            8'h01: if (n >= 3) begin
                s_sx = (int'(tx_q[1]) * 256 + int'(tx_q[2])) % 1024;
                m_pend = 1'b1;
            end
            8'h02: if (n >= 3) begin
                s_sy = (int'(tx_q[1]) * 256 + int'(tx_q[2])) % 1024;
                m_pend = 1'b1;
            end
            8'h03: if (n >= 4) begin
                s_bg = int'(tx_q[1]) % 64;
                s_c1 = int'(tx_q[2]) % 64;
                s_c2 = int'(tx_q[3]) % 64;
                m_pend = 1'b1;
            end
            default: ;
        endcase
        if (nf_last) begin
            model_commit();
            chk("simul_x", nf_snap, m_sx);
        end
    endtask

    task automatic frame_pulse();
        @(negedge clk);
        next_frame = 1'b1;
        check_active("pre_frame");
        @(negedge clk);
        next_frame = 1'b0;
        model_commit();
        check_active("post_frame");
    endtask

    initial begin
        logic [7:0] r;
        int kind, nb;
        logic [7:0] op;
        reset_n = 1'b0;
        spi_cs = 1'b1;
        spi_sclk = 1'b0;
        spi_mosi = 1'b0;
        next_frame = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_active("reset");
        chk("reset_wr_en", spr_wr_en, 0);
        chk("reset_wr_addr", spr_wr_addr, 0);
        chk("reset_wr_data", spr_wr_data, 0);
        chk("reset_miso", spi_miso, 0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        tx_q = '{8'h01, 8'h01, 8'h2C};
        apply_txn(0);
        chk("x_before_frame", sprite_x, 0);
        frame_pulse();
        chk("x_300", sprite_x, 300);

        tx_q.delete();
        tx_q.push_back(8'h04);
        for (int i = 0; i < 20; i++) tx_q.push_back(8'(8'hA0 + i));
        apply_txn(0);
        if (wa_q.size() == 20) begin
            chk("wrap_last_addr", wa_q[19], 1);
            chk("wrap_last_data", wd_q[19], 8'hB3);
        end

        tx_q = '{8'h03, 8'h15, 8'h2A};
        apply_txn(0);
        frame_pulse();
        chk("abort_bg", color_bg, 6'h00);
        chk("abort_c1", color_1, 6'h3F);
        chk("abort_c2", color_2, 6'h30);

        frame_pulse();
        tx_q = '{8'h02, 8'h00, 8'h64};
        apply_txn(0);
        tx_q = '{8'h05, 8'h00};
        apply_txn(0);
        chk("status_83", rx_q[1], 8'h83);

        tx_q = '{8'h01, 8'h03, 8'hFF};
        apply_txn(1);
        chk("simul_1023", nf_snap, 1023);
        tx_q = '{8'h05, 8'h00, 8'h00};
        apply_txn(0);
        chk("simul_pend0", rx_q[1], 8'h04);

        tx_q = '{8'h7E, 8'h01, 8'h02, 8'h03};
        apply_txn(0);
        frame_pulse();

        for (int it = 0; it < 30; it++) begin
            kind = $urandom_range(0, 5);
            tx_q.delete();
            case (kind)
                0, 1, 2: begin
                    op = 8'(kind + 1);
                    nb = ((kind == 2) ? 3 : 2) + $urandom_range(0, 3) - 1;
                end
                3: begin op = 8'h04; nb = $urandom_range(0, 22); end
                4: begin op = 8'h05; nb = $urandom_range(1, 2); end
                default: begin
                    op = 8'($urandom_range(5, 255));
                    if (op == 8'h05) op = 8'h00;
                    nb = $urandom_range(0, 3);
                end
            endcase
            tx_q.push_back(op);
            for (int j = 0; j < nb; j++) tx_q.push_back(8'($urandom));
            apply_txn(0);
            check_active("rand");
            if ($urandom_range(0, 1) == 1) frame_pulse();
        end

        @(negedge clk);
        spi_cs = 1'b0;
        repeat (HALF) @(negedge clk);
        spi_xfer(8'h05, 0, r);
        @(negedge clk);
        spi_sclk = 1'b1;
        repeat (HALF) @(negedge clk);
        spi_sclk = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_active("midreset");
        chk("midreset_wr_en", spr_wr_en, 0);
        chk("midreset_addr", spr_wr_addr, 0);
        chk("midreset_data", spr_wr_data, 0);
        chk("midreset_miso", spi_miso, 0);
        spi_cs = 1'b1;
        spi_mosi = 1'b0;
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        tx_q = '{8'h05, 8'h00};
        apply_txn(0);
        chk("post_reset_status", rx_q[1], 8'h00);
        check_active("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_cfg_ctrl.md
# sprite_cfg_ctrl

SPI command controller that configures the sprite display engine. It deserializes SPI mode-0 traffic from the bidirectional PMOD and decodes command frames. Position and colour updates go through shadow registers, which are copied to the active registers on the frame boundary so the display never tears. Sprite bitmap bytes are forwarded to the sprite memory write port, and one command returns a status byte on MISO. It sits between the SPI pins and the SVGA sprite datapath inside `top`.

## Interface
- `SPRITE_BYTES`, 18: bitmap size in bytes; the write address wraps after SPRITE_BYTES-1.
- `ADDR_W`, 5: width of the sprite write address.
- `clk`  in  1  system (pixel) clock.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `spi_sclk`  in  1  SPI clock, asynchronous to clk.
- `spi_mosi`  in  1  SPI data in, asynchronous.
- `spi_cs`  in  1  SPI chip select, active-low, asynchronous.
- `spi_miso`  out  1  SPI data out.
- `next_frame`  in  1  one-clk pulse at the frame boundary, from timing gen.
- `sprite_x`  out  10  active sprite X.
- `sprite_y`  out  10  active sprite Y.
- `color_bg`, `color_1`, `color_2`  out  6 each  active RRGGBB colours.
- `spr_wr_en`  out  1  one-clk write strobe to sprite memory.
- `spr_wr_addr`  out  ADDR_W  sprite byte address.
- `spr_wr_data`  out  8  sprite byte.

## Operation
- **Input synchronisation**
  - sclk, mosi and cs each pass through a 2-flop synchroniser; sclk edges are detected on the synchronised signal.
  - clk must be at least 4x sclk.
- **SPI mode 0**
  - MOSI is sampled on the sclk rising edge, MSB first.
  - The MISO register shifts on the sclk falling edge.
- **Bit and byte counting**
  - A 3-bit bit counter and a byte index (0 = command byte) reset whenever cs is high.
  - A byte is complete on the 8th sampled rising edge.
- **Command FSM**
  - States: IDLE → CMD → ARGS / SPRITE / STATUS / DISCARD.
  - cs high forces IDLE from any state.
  - Byte 0 is the opcode:
    - 0x01 SET_X: 2 argument bytes, big-endian, low 10 bits used.
    - 0x02 SET_Y: same format as SET_X.
    - 0x03 SET_COLORS: 3 bytes in order bg, c1, c2, low 6 bits of each.
    - 0x04 WRITE_SPRITE: every following byte is a sprite byte. The address starts at 0 per transaction, increments after each byte, and wraps SPRITE_BYTES-1 → 0.
    - 0x05 READ_STATUS: returns a status byte.
    - Any other opcode, including 0x00: DISCARD, bytes ignored until cs goes high.
- **Argument staging**
  - Argument bytes collect in a staging register.
  - The shadow register is written only when the last argument byte completes, and `pending` is then set.
  - Extra bytes after a complete SET_* go to DISCARD.
  - cs going high mid-command drops the partial staging; shadow and pending are unchanged.
- **Frame commit**
  - On `next_frame`, active ← shadow for all five fields and `pending` clears.
  - If a shadow commit and `next_frame` fall in the same clk, the active registers take the newly committed value and `pending` ends 0.
- **Frame counter**: 8-bit frame_cnt increments on every `next_frame` and wraps 255 → 0.
- **Status read (READ_STATUS)**
  - Status byte = {pending, frame_cnt[6:0]}, captured when the opcode completes.
  - Loaded into the tx register on the sclk falling edge that ends byte 0, then shifted on each falling edge within later bytes.
  - After 8 bits, MISO outputs 0.
- **MISO idle level**: 0 while cs is high or outside STATUS.

## Timing
- **Reset values**
  - sprite_x = 0, sprite_y = 0 (shadow identical).
  - color_bg = 6'h00, color_1 = 6'h3F, color_2 = 6'h30.
  - spr_wr_en = 0, spr_wr_addr = 0, spr_wr_data = 0, spi_miso = 0.
  - pending = 0, frame_cnt = 0, FSM in IDLE.
- **spr_wr_en**: single-clk pulse no later than 4 clk after the synchronised 8th rising edge; addr and data are valid in the same cycle.
- **Commit to active**: active outputs change exactly 1 clk after the `next_frame` pulse (registered), never at any other time.
- **Shadow write**: 1 clk after byte completion.
- **Reset mid-transaction**: reset_n low clears everything immediately and asynchronously.

## Test plan
- **Reset**: assert reset_n=0 mid-SPI → all outputs at reset values; miso = 0.
- **Frame-synchronous update**: send 0x01 0x01 0x2C, no `next_frame` → sprite_x stays 0; pulse `next_frame` → sprite_x = 300 one clk later, pending = 0.
- **Sprite write with wrap**: send 0x04 followed by 20 bytes 0xA0..0xB3 → 20 strobes at addr 0..17 then 0, 1; the last strobe carries addr 1, data 0xB3.
- **Abort**: send 0x03 0x15 0x2A, then raise cs → colours and pending unchanged after `next_frame`.
- **Status read**: after 3 `next_frame` pulses plus a committed SET_Y, send 0x05 and clock 8 more bits → MISO reads 0x83.
- **Simultaneous commit and frame**: complete a SET_X of 0x3FF in the same clk as `next_frame` → sprite_x = 1023 the next clk, pending = 0; an unknown opcode 0x7E is ignored.
